uart_rx_deser: RTL
==================

Name: uart_rx_deser

Overview:
Receive-side deserializer for the UART. It takes the asynchronous serial line from the link or the loopback path, oversamples it with the baud-generator tick, and reconstructs 8N1 frames. Each good byte is pushed into the RX FIFO, which then drives rx_data and rx_empty. Framing errors and FIFO overruns are reported to the host side.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first.
OVERSAMPLE, 16, baud ticks per bit period. Must be 16 or greater.

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-low reset
baud_tick_i  input  1  one-clk strobe at OVERSAMPLE x the selected baud rate
rx_d  input  1  serial line; idle high; asynchronous to clk_i
fifo_full_i  input  1  RX FIFO full
ovr_clr_i  input  1  clears overrun_o
wr_en_o  output  1  one-cycle push strobe to the RX FIFO
wr_data_o  output  DATA_BITS  received byte; valid while wr_en_o=1
frame_err_o  output  1  one-cycle pulse on a bad stop bit
overrun_o  output  1  sticky: a good byte was dropped because the FIFO was full
busy_o  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state = IDLE.
  - Both synchronizer flops = 1.
  - wr_en_o = 0, wr_data_o = 0, frame_err_o = 0, overrun_o = 0, busy_o = 0.
  - All counters and the shift register = 0.
  - Reset mid-frame abandons the partial byte; nothing is pushed.
- Input synchronization:
  - rx_d passes through a 2-flop synchronizer; the second flop output is rx_s.
  - All decisions use rx_s only.
- Tick counter:
  - tcnt counts 0..OVERSAMPLE-1, advances only on baud_tick_i, and wraps to 0 at the end of each bit.
  - Samples are taken at tcnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8, 9 at default).
  - The bit value is the 2-of-3 majority of those samples, evaluated on the tick where tcnt = OVERSAMPLE/2+1.
- States:
  - IDLE:
    - On a baud_tick_i with rx_s=0, go to START with tcnt=1; that tick counts as sample 0.
    - Otherwise stay.
  - START:
    - At the majority point: majority=1 is a false start; go to IDLE with no error.
    - Majority=0: continue.
    - At the tcnt wrap go to DATA with bitcnt=0.
  - DATA:
    - At each majority point, shift the voted bit into the MSB of the shift register (right shift, LSB-first reception).
    - At the tcnt wrap, increment bitcnt.
    - After DATA_BITS bits go to STOP.
  - STOP:
    - Vote=1 (good frame): at the majority point go to IDLE without waiting out the rest of the stop bit. If fifo_full_i=0, push the byte; if fifo_full_i=1, set overrun_o and do not push.
    - Vote=0: pulse frame_err_o, do not push, go to BRK.
  - BRK: wait for a baud_tick_i with rx_s=1, then go to IDLE. This prevents a held-low line or break from re-triggering starts.
- Output timing:
  - wr_en_o, wr_data_o and frame_err_o are registered.
  - They assert on the clk edge after the stop-bit majority tick and last exactly one cycle.
  - wr_data_o holds its value until the next push.
- Overrun:
  - overrun_o stays set until ovr_clr_i=1.
  - If a set and a clear happen in the same cycle, the set wins.
- fifo_full_i is sampled only on the stop-bit majority tick.
- With baud_tick_i held low, the FSM freezes; only the synchronizer and ovr_clr_i act.
- busy_o = (state != IDLE), registered with the state.
- End-to-end latency: about 9.5 bit periods from the start-bit falling edge to wr_en_o, plus 2 synchronizer cycles.

Test Plan:
- baud_tick_i=1 every cycle; drive frame 0x5A (start 0, bits 0,1,0,1,1,0,1,0, stop 1), 16 clk per bit → exactly one wr_en_o pulse, wr_data_o=0x5A, frame_err_o=0, overrun_o=0.
- Back-to-back frames 0x88, 0x44, 0x22, 0x11 with no idle gap → four pushes in order with matching data, no errors.
- rx_d low for 4 ticks, then high → returns to IDLE, no push, no frame_err_o; busy_o high only during the glitch.
- Frame 0xA5 with stop bit held 0 for 40 ticks, then high → one frame_err_o pulse, no push, busy_o high until the line returns high; a following 0x3C frame is received correctly.
- fifo_full_i=1 during frame 0x77 → no wr_en_o, overrun_o=1 and held; pulse ovr_clr_i → overrun_o=0; ovr_clr_i asserted on the same cycle as a new overrun → overrun_o stays 1.
- A 1-tick inverted sample at tcnt=8 of data bit 3 of frame 0x0F → wr_data_o=0x0F (majority vote corrects it). Separately, rst_i=0 during bit 4 of a frame, release, send 0x5A → only 0x5A is pushed.

Source files
------------

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronizes the serial line, oversamples each bit with a
// 2-of-3 majority vote, rebuilds 8N1 frames and pushes good bytes into the RX FIFO.
module uart_rx_deser #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 baud_tick_i,
   input  logic                 rx_d,
   input  logic                 fifo_full_i,
   input  logic                 ovr_clr_i,
   output logic                 wr_en_o,
   output logic [DATA_BITS-1:0] wr_data_o,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_MAJ  = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } state_t;

   state_t               state_r;
   logic [1:0]           sync_r;
   logic [TW-1:0]        tcnt_r;
   logic [BW-1:0]        bitcnt_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 smp0_r;
   logic                 smp1_r;
   logic                 wr_en_r;
   logic [DATA_BITS-1:0] wr_data_r;
   logic                 frame_err_r;
   logic                 overrun_r;
   logic                 busy_r;
   logic                 rx_s;
   logic                 vote_s;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign rx_s   = sync_r[1];
   assign vote_s = maj3(smp0_r, smp1_r, rx_s);

   assign wr_en_o     = wr_en_r;
   assign wr_data_o   = wr_data_r;
   assign frame_err_o = frame_err_r;
   assign overrun_o   = overrun_r;
   assign busy_o      = busy_r;

   // Two-flop synchronizer for the asynchronous serial line, idling high.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], rx_d};
      end
   end

   // Frame FSM with tick counter, sampling, shift register and registered outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r     <= ST_IDLE;
         tcnt_r      <= '0;
         bitcnt_r    <= '0;
         shift_r     <= '0;
         smp0_r      <= 1'b0;
         smp1_r      <= 1'b0;
         wr_en_r     <= 1'b0;
         wr_data_r   <= '0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         wr_en_r     <= 1'b0;
         frame_err_r <= 1'b0;
         // A set later in this block overrides the clear when both land together.
         if (ovr_clr_i) begin
            overrun_r <= 1'b0;
         end

         if (baud_tick_i) begin
            if (state_r == ST_START || state_r == ST_DATA || state_r == ST_STOP) begin
               tcnt_r <= (tcnt_r == T_LAST) ? '0 : tcnt_r + TW'(1);
               if (tcnt_r == T_S0) begin
                  smp0_r <= rx_s;
               end
               if (tcnt_r == T_S1) begin
                  smp1_r <= rx_s;
               end
            end

            case (state_r)
               ST_IDLE: begin
                  if (!rx_s) begin
                     state_r <= ST_START;
                     tcnt_r  <= TW'(1);
                     busy_r  <= 1'b1;
                  end
               end
               ST_START: begin
                  if (tcnt_r == T_MAJ && vote_s) begin
                     state_r <= ST_IDLE;
                     tcnt_r  <= '0;
                     busy_r  <= 1'b0;
                  end else if (tcnt_r == T_LAST) begin
                     state_r  <= ST_DATA;
                     bitcnt_r <= '0;
                  end
               end
               ST_DATA: begin
                  if (tcnt_r == T_MAJ) begin
                     shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
                  end
                  if (tcnt_r == T_LAST) begin
                     if (bitcnt_r == B_LAST) begin
                        state_r  <= ST_STOP;
                        bitcnt_r <= '0;
                     end else begin
                        bitcnt_r <= bitcnt_r + BW'(1);
                     end
                  end
               end
               ST_STOP: begin
                  if (tcnt_r == T_MAJ) begin
                     tcnt_r <= '0;
                     if (vote_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        if (fifo_full_i) begin
                           overrun_r <= 1'b1;
                        end else begin
                           wr_en_r   <= 1'b1;
                           wr_data_r <= shift_r;
                        end
                     end else begin
                        frame_err_r <= 1'b1;
                        state_r     <= ST_BRK;
                     end
                  end
               end
               ST_BRK: begin
                  // Hold here until the line recovers so a break cannot re-trigger a start.
                  if (rx_s) begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  tcnt_r  <= '0;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
